// File: rtl/bus_width_upsizer.sv
// Narrow-to-wide stream packer: RATIO input beats (or a packet end) form one output word with lane keep mask.
// Optional idle flush of a partial word is enabled with `define BUS_UPSIZE_FLUSH_EN.
module bus_width_upsizer #(
    parameter int SIZE_IN       = 8,
    parameter int SIZE_OUT      = 32,
    parameter bit LITTLE_ENDIAN = 1'b1,
    parameter int FLUSH_CYCLES  = 16,
    localparam int RATIO        = SIZE_OUT / SIZE_IN
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                input_ready,
    input  logic                input_valid,
    input  logic [SIZE_IN-1:0]  input_data,
    input  logic                input_last,
    input  logic                output_ready,
    output logic                output_valid,
    output logic [SIZE_OUT-1:0] output_data,
    output logic [RATIO-1:0]    output_keep,
    output logic                output_last
);

    localparam int PW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [PW-1:0] FIRST_LANE = LITTLE_ENDIAN ? PW'(0) : PW'(RATIO - 1);
    localparam logic [PW-1:0] LAST_LANE  = LITTLE_ENDIAN ? PW'(RATIO - 1) : PW'(0);

    if ((SIZE_OUT % SIZE_IN) != 0 || RATIO < 2 || FLUSH_CYCLES < 1) begin : g_bad_cfg
        $error("bus_width_upsizer: SIZE_OUT must be a multiple (>=2) of SIZE_IN, FLUSH_CYCLES >= 1");
    end

    typedef enum logic {FILL, PENDING} state_t;

    state_t state, state_next;

    logic [RATIO-1:0][SIZE_IN-1:0] asm_data, word_data;
    logic [RATIO-1:0]              asm_keep, word_keep;
    logic                          asm_last, word_last;
    logic [PW-1:0]                 ptr;

    logic beat, complete, flush_hit, slot_free;
    logic load_word, load_asm, store_pend;

    assign input_ready = (state == FILL);
    assign beat        = input_valid && input_ready;
    assign complete    = beat && ((ptr == LAST_LANE) || input_last);
    assign slot_free   = !output_valid || output_ready;

`ifdef BUS_UPSIZE_FLUSH_EN
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    logic [CW-1:0] idle_cnt;

    assign flush_hit = (state == FILL) && !beat && (|asm_keep) && (idle_cnt == CW'(FLUSH_CYCLES));

    // Counts only while a partial word is waiting in FILL; any beat restarts the wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            idle_cnt <= '0;
        else if (beat || state != FILL || !(|asm_keep))
            idle_cnt <= '0;
        else if (idle_cnt != CW'(FLUSH_CYCLES))
            idle_cnt <= idle_cnt + CW'(1);
    end
`else
    assign flush_hit = 1'b0;
`endif

    // Word candidate: assembly merged with the beat (if any) of this cycle.
    always_comb begin
        word_data = asm_data;
        word_keep = asm_keep;
        word_last = 1'b0;
        if (beat) begin
            word_data[ptr] = input_data;
            word_keep[ptr] = 1'b1;
            word_last      = input_last;
        end
    end

    always_comb begin
        state_next = state;
        load_word  = 1'b0;
        load_asm   = 1'b0;
        store_pend = 1'b0;
        case (state)
            FILL: begin
                if (complete || flush_hit) begin
                    if (slot_free) begin
                        load_word = 1'b1;
                    end else begin
                        store_pend = 1'b1;
                        state_next = PENDING;
                    end
                end
            end
            PENDING: begin
                // output_valid is always high here, so output_ready means the slot empties this edge.
                if (output_ready) begin
                    load_asm   = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= FILL;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_data <= '0;
            asm_keep <= '0;
            asm_last <= 1'b0;
            ptr      <= FIRST_LANE;
        end else if (load_word || load_asm) begin
            asm_data <= '0;
            asm_keep <= '0;
            asm_last <= 1'b0;
            ptr      <= FIRST_LANE;
        end else if (store_pend) begin
            asm_data <= word_data;
            asm_keep <= word_keep;
            asm_last <= word_last;
            ptr      <= FIRST_LANE;
        end else if (beat) begin
            asm_data <= word_data;
            asm_keep <= word_keep;
            ptr      <= LITTLE_ENDIAN ? ptr + PW'(1) : ptr - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            output_valid <= 1'b0;
            output_data  <= '0;
            output_keep  <= '0;
            output_last  <= 1'b0;
        end else if (load_word) begin
            output_valid <= 1'b1;
            output_data  <= word_data;
            output_keep  <= word_keep;
            output_last  <= word_last;
        end else if (load_asm) begin
            output_valid <= 1'b1;
            output_data  <= asm_data;
            output_keep  <= asm_keep;
            output_last  <= asm_last;
        end else if (output_ready) begin
            output_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_width_upsizer.sv
// Directed bench for bus_width_upsizer: little- and big-endian 8->32 instances driven by a shared stream.
// The idle-flush scenario follows the BUS_UPSIZE_FLUSH_EN build setting.
module tb_bus_width_upsizer;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic        le_in_ready, le_valid, le_last;
    logic [31:0] le_data;
    logic [3:0]  le_keep;
    logic        be_in_ready, be_valid, be_last;
    logic [31:0] be_data;
    logic [3:0]  be_keep;

    int checks   = 0;
    int failures = 0;

    bus_width_upsizer #(.SIZE_IN(8), .SIZE_OUT(32), .LITTLE_ENDIAN(1'b1), .FLUSH_CYCLES(4)) dut_le (
        .clk(clk), .reset_n(reset_n),
        .input_ready(le_in_ready), .input_valid(in_valid), .input_data(in_data), .input_last(in_last),
        .output_ready(out_ready), .output_valid(le_valid), .output_data(le_data),
        .output_keep(le_keep), .output_last(le_last)
    );

    bus_width_upsizer #(.SIZE_IN(8), .SIZE_OUT(32), .LITTLE_ENDIAN(1'b0), .FLUSH_CYCLES(4)) dut_be (
        .clk(clk), .reset_n(reset_n),
        .input_ready(be_in_ready), .input_valid(in_valid), .input_data(in_data), .input_last(in_last),
        .output_ready(out_ready), .output_valid(be_valid), .output_data(be_data),
        .output_keep(be_keep), .output_last(be_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'hEE;
    endtask

    initial begin
        logic [31:0] exp_w;
        int          ready_drops;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", {63'd0, le_valid}, 64'd0);
        chk("rst_data",  {32'd0, le_data}, 64'd0);
        chk("rst_keep",  {60'd0, le_keep}, 64'd0);
        chk("rst_last",  {63'd0, le_last}, 64'd0);
        reset_n = 1'b1;
        step();
        chk("rst_ready", {63'd0, le_in_ready}, 64'd1);

        // full word, both endiannesses
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("t1_not_yet", {63'd0, le_valid}, 64'd0);
        send(8'h44, 1'b0);
        chk("t1_valid",   {63'd0, le_valid}, 64'd1);
        chk("t1_le_data", {32'd0, le_data}, 64'h44332211);
        chk("t1_le_keep", {60'd0, le_keep}, 64'hF);
        chk("t1_le_last", {63'd0, le_last}, 64'd0);
        chk("t2_be_data", {32'd0, be_data}, 64'h11223344);
        chk("t2_be_keep", {60'd0, be_keep}, 64'hF);
        step();
        chk("t1_drop", {63'd0, le_valid}, 64'd0);

        // packet end closes a partial word; next packet restarts at the first lane
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        chk("t3_le_data", {32'd0, le_data}, 64'h0000BBAA);
        chk("t3_le_keep", {60'd0, le_keep}, 64'h3);
        chk("t3_le_last", {63'd0, le_last}, 64'd1);
        chk("t3_be_data", {32'd0, be_data}, 64'hAABB0000);
        chk("t3_be_keep", {60'd0, be_keep}, 64'hC);
        send(8'hCC, 1'b1);
        chk("t3_one_data", {32'd0, le_data}, 64'h000000CC);
        chk("t3_one_keep", {60'd0, le_keep}, 64'h1);
        chk("t3_be_one",   {32'd0, be_data}, 64'hCC000000);
        chk("t3_be_okeep", {60'd0, be_keep}, 64'h8);
        step();

        // backpressure: second word parks in the assembly, input stalls
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        chk("t4_w1_valid", {63'd0, le_valid}, 64'd1);
        chk("t4_w1_data",  {32'd0, le_data}, 64'h04030201);
        for (int i = 5; i <= 8; i++) send(8'(i), 1'b0);
        chk("t4_ready_lo",  {63'd0, le_in_ready}, 64'd0);
        chk("t4_be_rdy_lo", {63'd0, be_in_ready}, 64'd0);
        step();
        step();
        chk("t4_hold_valid", {63'd0, le_valid}, 64'd1);
        chk("t4_hold_data",  {32'd0, le_data}, 64'h04030201);
        out_ready = 1'b1;
        step();
        chk("t4_w2_valid", {63'd0, le_valid}, 64'd1);
        chk("t4_w2_data",  {32'd0, le_data}, 64'h08070605);
        chk("t4_w2_keep",  {60'd0, le_keep}, 64'hF);
        chk("t4_ready_hi", {63'd0, le_in_ready}, 64'd1);
        step();
        chk("t4_drain", {63'd0, le_valid}, 64'd0);

        // sustained rate: 16 beats, a word every 4th cycle, no input stall
        ready_drops = 0;
        for (int k = 0; k < 16; k++) begin
            if (!le_in_ready) ready_drops++;
            send(8'h20 + 8'(k), 1'b0);
            if (k % 4 == 3) begin
                exp_w = {8'h20 + 8'(k), 8'h20 + 8'(k - 1), 8'h20 + 8'(k - 2), 8'h20 + 8'(k - 3)};
                chk($sformatf("t5_valid_%0d", k), {63'd0, le_valid}, 64'd1);
                chk($sformatf("t5_data_%0d", k), {32'd0, le_data}, {32'd0, exp_w});
            end else begin
                chk($sformatf("t5_gap_%0d", k), {63'd0, le_valid}, 64'd0);
            end
        end
        chk("t5_ready_drops", 64'(ready_drops), 64'd0);
        step();

        // partial word left idle
        send(8'h5A, 1'b0);
`ifdef BUS_UPSIZE_FLUSH_EN
        for (int i = 0; i < 4; i++) step();
        chk("t6_pre_flush", {63'd0, le_valid}, 64'd0);
        step();
        chk("t6_flush_valid", {63'd0, le_valid}, 64'd1);
        chk("t6_flush_data",  {32'd0, le_data}, 64'h0000005A);
        chk("t6_flush_keep",  {60'd0, le_keep}, 64'h1);
        chk("t6_flush_last",  {63'd0, le_last}, 64'd0);
        step();
`else
        for (int i = 0; i < 8; i++) step();
        chk("t6_no_flush", {63'd0, le_valid}, 64'd0);
        send(8'h6B, 1'b1);
        chk("t6_join_data", {32'd0, le_data}, 64'h00006B5A);
        chk("t6_join_keep", {60'd0, le_keep}, 64'h3);
        chk("t6_join_last", {63'd0, le_last}, 64'd1);
        step();
`endif

        // reset mid-packet with a word in the output slot
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i), 1'b0);
        send(8'hB1, 1'b0);
        chk("t6_pre_rst_valid", {63'd0, le_valid}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", {63'd0, le_valid}, 64'd0);
        chk("t6_rst_data",  {32'd0, le_data}, 64'd0);
        chk("t6_rst_keep",  {60'd0, le_keep}, 64'd0);
        chk("t6_rst_last",  {63'd0, le_last}, 64'd0);
        chk("t6_rst_bedata", {32'd0, be_data}, 64'd0);
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        step();
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b1);
        chk("t6_after_data", {32'd0, le_data}, 64'h0000C2C1);
        chk("t6_after_keep", {60'd0, le_keep}, 64'h3);
        chk("t6_after_last", {63'd0, le_last}, 64'd1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
